// File: rtl/layer3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | layer3_pkg: state encoding and weight-port word counts for the layer-3   |
// | stage (one conv block followed by five identity blocks).                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package layer3_pkg;

  localparam int NUM_PORTS   = 19;
  localparam int COUNT_WIDTH = 24;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;

  function automatic logic [COUNT_WIDTH-1:0] conv_words(input int k, input int cin, input int cout);
    return COUNT_WIDTH'(k * k * cin * cout);
  endfunction

  localparam logic [COUNT_WIDTH-1:0] CB_W1 = conv_words(1, 512, 256);
  localparam logic [COUNT_WIDTH-1:0] CB_W2 = conv_words(3, 256, 256);
  localparam logic [COUNT_WIDTH-1:0] CB_W3 = conv_words(1, 256, 1024);
  localparam logic [COUNT_WIDTH-1:0] CB_SC = conv_words(1, 512, 1024);
  localparam logic [COUNT_WIDTH-1:0] ID_W1 = conv_words(1, 1024, 256);
  localparam logic [COUNT_WIDTH-1:0] ID_W2 = conv_words(3, 256, 256);
  localparam logic [COUNT_WIDTH-1:0] ID_W3 = conv_words(1, 256, 1024);

  // Port 1 occupies the least-significant slice; port 19 the most significant.
  localparam logic [NUM_PORTS*COUNT_WIDTH-1:0] WEIGHT_COUNTS =
    {{5{ID_W3, ID_W2, ID_W1}}, CB_SC, CB_W3, CB_W2, CB_W1};

endpackage
`default_nettype wire

// File: rtl/layer3_port_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | layer3_port_counter: tracks the current weight port and its word count,  |
// | flagging the last word of a port and the last port of the stage.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module layer3_port_counter #(
  parameter int NUM_PORTS   = layer3_pkg::NUM_PORTS,
  parameter int COUNT_WIDTH = layer3_pkg::COUNT_WIDTH,
  parameter logic [NUM_PORTS*COUNT_WIDTH-1:0] WEIGHT_COUNTS = layer3_pkg::WEIGHT_COUNTS,
  parameter int SEL_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             adv_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             last_word_o,
  output logic             last_port_o
);
  import layer3_pkg::*;

  logic [COUNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [COUNT_WIDTH-1:0] port_count;
  logic [SEL_W-1:0]       sel_q, sel_d;

  always_comb begin
    port_count = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel_q == SEL_W'(k)) port_count = WEIGHT_COUNTS[k*COUNT_WIDTH +: COUNT_WIDTH];
    end
  end

  assign last_word_o = (wcnt_q == port_count - COUNT_WIDTH'(1));
  assign last_port_o = (sel_q == SEL_W'(NUM_PORTS - 1));
  assign sel_o       = sel_q;

  always_comb begin
    wcnt_d = wcnt_q;
    sel_d  = sel_q;
    if (clear_i) begin
      wcnt_d = '0;
      sel_d  = '0;
    end else if (adv_i) begin
      if (last_word_o) begin
        wcnt_d = '0;
        // Parking at 0 after the final port keeps the lookup index in range.
        sel_d  = last_port_o ? '0 : sel_q + SEL_W'(1);
      end else begin
        wcnt_d = wcnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      sel_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      sel_q  <= sel_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/layer3_weight_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | layer3_weight_sequencer: steers a serial weight stream to the 19 layer-3 |
// | weight ports, then passes exactly one frame of pixels.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module layer3_weight_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 64,
  parameter int NUM_PORTS    = layer3_pkg::NUM_PORTS,
  parameter int COUNT_WIDTH  = layer3_pkg::COUNT_WIDTH,
  parameter logic [NUM_PORTS*COUNT_WIDTH-1:0] WEIGHT_COUNTS = layer3_pkg::WEIGHT_COUNTS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  valid_weight_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic [NUM_PORTS-1:0]  valid_weight_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  busy,
  output logic                  load_done,
  output logic                  frame_done
);
  import layer3_pkg::*;

  localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PCNT_W       = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int SEL_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [NUM_PORTS-1:0] ONE_HOT_0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic [DATA_WIDTH-1:0] weight_out_q, weight_out_d;
  logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
  logic [NUM_PORTS-1:0]  vwo_q, vwo_d;
  logic                  valid_out_q, valid_out_d;
  logic                  busy_q, busy_d;
  logic                  load_done_q, load_done_d;
  logic                  frame_done_q, frame_done_d;

  logic [SEL_W-1:0]      sel;
  logic                  last_word, last_port;
  logic                  cnt_clear, cnt_adv;

  layer3_port_counter #(
    .NUM_PORTS     (NUM_PORTS),
    .COUNT_WIDTH   (COUNT_WIDTH),
    .WEIGHT_COUNTS (WEIGHT_COUNTS),
    .SEL_W         (SEL_W)
  ) u_port_counter (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (cnt_clear),
    .adv_i       (cnt_adv),
    .sel_o       (sel),
    .last_word_o (last_word),
    .last_port_o (last_port)
  );

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    weight_out_d = weight_out_q;
    pxl_out_d    = pxl_out_q;
    vwo_d        = '0;
    valid_out_d  = 1'b0;
    load_done_d  = 1'b0;
    frame_done_d = 1'b0;
    cnt_clear    = 1'b0;
    cnt_adv      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (valid_weight_in) begin
          cnt_adv      = 1'b1;
          weight_out_d = weight_in;
          vwo_d        = ONE_HOT_0 << sel;
          if (last_word && last_port) begin
            load_done_d = 1'b1;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (valid_in) begin
          valid_out_d = 1'b1;
          pxl_out_d   = pxl_in;
          if (pcnt_q == PCNT_W'(FRAME_PIXELS - 1)) begin
            frame_done_d = 1'b1;
            pcnt_d       = '0;
            state_d      = ST_IDLE;
          end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Hold busy through the frame_done cycle so it drops right after it.
    busy_d = (state_d != ST_IDLE) || frame_done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pcnt_q       <= '0;
      weight_out_q <= '0;
      pxl_out_q    <= '0;
      vwo_q        <= '0;
      valid_out_q  <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      weight_out_q <= weight_out_d;
      pxl_out_q    <= pxl_out_d;
      vwo_q        <= vwo_d;
      valid_out_q  <= valid_out_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign weight_out       = weight_out_q;
  assign valid_weight_out = vwo_q;
  assign valid_out        = valid_out_q;
  assign pxl_out          = pxl_out_q;
  assign busy             = busy_q;
  assign load_done        = load_done_q;
  assign frame_done       = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_layer3_weight_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_layer3_weight_sequencer: directed bench, 8x8 frame, mixed port counts |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_layer3_weight_sequencer;

  localparam int DW       = 32;
  localparam int NP       = 19;
  localparam int CW       = 24;
  localparam int IMG_W    = 8;
  localparam int IMG_H    = 8;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int TOTAL_W  = 38;
  // Port 1 takes 1 word, port 2 takes 3, ports 3..19 take 2 each: 38 words.
  localparam logic [NP*CW-1:0] TB_COUNTS = {{17{24'd2}}, 24'd3, 24'd1};

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          valid_weight_in;
  logic [DW-1:0] weight_in;
  logic          valid_in;
  logic [DW-1:0] pxl_in;
  logic [DW-1:0] weight_out;
  logic [NP-1:0] valid_weight_out;
  logic          valid_out;
  logic [DW-1:0] pxl_out;
  logic          busy;
  logic          load_done;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  int tb_cnt[NP];
  int exp_port[TOTAL_W];

  layer3_weight_sequencer #(
    .DATA_WIDTH    (DW),
    .IMAGE_WIDTH   (IMG_W),
    .IMAGE_HEIGHT  (IMG_H),
    .NUM_PORTS     (NP),
    .COUNT_WIDTH   (CW),
    .WEIGHT_COUNTS (TB_COUNTS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .valid_weight_in  (valid_weight_in),
    .weight_in        (weight_in),
    .valid_in         (valid_in),
    .pxl_in           (pxl_in),
    .weight_out       (weight_out),
    .valid_weight_out (valid_weight_out),
    .valid_out        (valid_out),
    .pxl_out          (pxl_out),
    .busy             (busy),
    .load_done        (load_done),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wout"}, 64'(weight_out), 64'd0);
    check({tag, "_vwo"}, 64'(valid_weight_out), 64'd0);
    check({tag, "_vout"}, 64'(valid_out), 64'd0);
    check({tag, "_pout"}, 64'(pxl_out), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ldone"}, 64'(load_done), 64'd0);
    check({tag, "_fdone"}, 64'(frame_done), 64'd0);
  endtask

  // Pixels ride along with every weight and must be dropped; start at start_at is ignored.
  task automatic load_words(input int n_words, input bit gaps, input int start_at);
    logic [63:0] e_vwo;
    for (int n = 0; n < n_words; n++) begin
      valid_weight_in = 1'b1;
      weight_in       = 32'hA000_0000 + n;
      valid_in        = 1'b1;
      pxl_in          = 32'hDEAD_0000 + n;
      start           = (n == start_at);
      @(negedge clk);
      e_vwo = 64'd1 << exp_port[n];
      check("w_strobe", 64'(valid_weight_out), e_vwo);
      check("w_data", 64'(weight_out), 64'(32'hA000_0000 + n));
      check("w_pix_drop", 64'(valid_out), 64'd0);
      check("w_load_done", 64'(load_done), 64'(n == TOTAL_W - 1));
      check("w_busy", 64'(busy), 64'd1);
      if (gaps && n != TOTAL_W - 1) begin
        valid_weight_in = 1'b0;
        valid_in        = 1'b0;
        start           = 1'b0;
        @(negedge clk);
        check("gap_strobe", 64'(valid_weight_out), 64'd0);
        check("gap_load_done", 64'(load_done), 64'd0);
      end
    end
    valid_weight_in = 1'b0;
    valid_in        = 1'b0;
    start           = 1'b0;
  endtask

  // Weights ride along with every pixel and must be dropped; start is pulsed mid-frame and at the last pixel.
  task automatic run_frame(input bit gaps);
    for (int k = 0; k < NPIX; k++) begin
      if (gaps && (k % 9 == 4)) begin
        valid_in        = 1'b0;
        valid_weight_in = 1'b1;
        start           = 1'b0;
        @(negedge clk);
        check("r_gap_vout", 64'(valid_out), 64'd0);
        check("r_gap_vwo", 64'(valid_weight_out), 64'd0);
      end
      valid_in        = 1'b1;
      pxl_in          = 32'h0000_0100 + k;
      valid_weight_in = 1'b1;
      weight_in       = 32'hBAD0_0000 + k;
      start           = (k == 20) || (k == NPIX - 1);
      @(negedge clk);
      check("r_vout", 64'(valid_out), 64'd1);
      check("r_pxl", 64'(pxl_out), 64'(32'h0000_0100 + k));
      check("r_vwo", 64'(valid_weight_out), 64'd0);
      check("r_frame_done", 64'(frame_done), 64'(k == NPIX - 1));
      check("r_busy", 64'(busy), 64'd1);
    end
    // Back in IDLE: busy drops, the start that met the last pixel had no effect, pixels are dropped.
    valid_in        = 1'b1;
    pxl_in          = 32'h0000_BEEF;
    valid_weight_in = 1'b0;
    start           = 1'b0;
    @(negedge clk);
    check("post_busy", 64'(busy), 64'd0);
    check("post_vout", 64'(valid_out), 64'd0);
    check("post_fdone", 64'(frame_done), 64'd0);
    valid_in = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    for (int p = 0; p < NP; p++) tb_cnt[p] = 2;
    tb_cnt[0] = 1;
    tb_cnt[1] = 3;
    n = 0;
    for (int p = 0; p < NP; p++) begin
      for (int c = 0; c < tb_cnt[p]; c++) begin
        exp_port[n] = p;
        n++;
      end
    end

    reset           = 1'b1;
    start           = 1'b0;
    valid_weight_in = 1'b0;
    weight_in       = '0;
    valid_in        = 1'b0;
    pxl_in          = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Traffic in IDLE is dropped.
    reset           = 1'b0;
    valid_in        = 1'b1;
    pxl_in          = 32'h1234_5678;
    valid_weight_in = 1'b1;
    weight_in       = 32'h8765_4321;
    @(negedge clk);
    check("idle_vout", 64'(valid_out), 64'd0);
    check("idle_vwo", 64'(valid_weight_out), 64'd0);
    check("idle_busy0", 64'(busy), 64'd0);

    // Gapped load with a start pulse at word 10, then a gapped frame.
    valid_in        = 1'b0;
    valid_weight_in = 1'b0;
    start           = 1'b1;
    @(negedge clk);
    check("start_busy", 64'(busy), 64'd1);
    check("start_vwo", 64'(valid_weight_out), 64'd0);
    load_words(TOTAL_W, 1'b1, 10);
    run_frame(1'b1);

    // Reset after 10 words discards the partial load.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_words(10, 1'b0, -1);
    reset           = 1'b1;
    valid_weight_in = 1'b1;
    valid_in        = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    reset           = 1'b0;
    valid_weight_in = 1'b0;
    valid_in        = 1'b0;
    start           = 1'b1;
    @(negedge clk);
    check("restart_busy", 64'(busy), 64'd1);
    load_words(TOTAL_W, 1'b0, -1);
    run_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer3_weight_sequencer.md
# layer3_weight_sequencer

Sequencer that sits in front of the ResNet-50 layer-3 stage (one conv block followed by five identity blocks). It takes a single serial weight stream, counts it, and steers each word to the correct one of the stage's 19 weight ports (port 1 to the last port in order). It then opens the pixel path for exactly one frame and returns to idle. This lets a single DMA channel configure the whole stage before each frame.

## Interface
Parameters:
- DATA_WIDTH, 32, width of weight and pixel words
- IMAGE_WIDTH, 64, input frame width in pixels
- IMAGE_HEIGHT, 64, input frame height in pixels
- NUM_PORTS, 19, number of weight ports driven (4 conv-block + 5×3 identity-block)
- COUNT_WIDTH, 24, width of per-port word counts
- WEIGHT_COUNTS, from package, packed NUM_PORTS*COUNT_WIDTH vector; slice k holds the word count for port k+1 (each ≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin weight load; honoured only in IDLE
- valid_weight_in  in  1  weight word valid
- weight_in  in  DATA_WIDTH  weight word
- valid_in  in  1  pixel valid from upstream
- pxl_in  in  DATA_WIDTH  pixel from upstream
- weight_out  out  DATA_WIDTH  weight word broadcast to all ports
- valid_weight_out  out  NUM_PORTS  one-hot strobe; bit k is valid for port k+1
- valid_out  out  1  pixel valid into the layer-3 stage
- pxl_out  out  DATA_WIDTH  pixel into the layer-3 stage
- busy  out  1  high in LOAD or RUN
- load_done  out  1  one-cycle pulse when the last weight of the last port is issued
- frame_done  out  1  one-cycle pulse when the last pixel of the frame is issued

## Operation
- States: IDLE, LOAD, RUN.
- **IDLE**
  - A rising `start` clears port index `sel` and word counter `wcnt`, then goes to LOAD.
  - Weights and pixels arriving in IDLE are dropped.
- **LOAD**, on each `valid_weight_in`:
  - `weight_out` is set to `weight_in`.
  - `valid_weight_out` is set to `1<<sel`.
  - `wcnt` increments.
  - When `wcnt == WEIGHT_COUNTS[sel]-1`: `wcnt` returns to 0 and `sel` increments.
  - If `sel == NUM_PORTS-1` at that point, `load_done` pulses and the state goes to RUN.
  - Pixels arriving in LOAD are dropped.
- **RUN**
  - Each `valid_in` is registered to `valid_out`/`pxl_out`, and pixel counter `pcnt` increments.
  - On pixel IMAGE_WIDTH*IMAGE_HEIGHT-1: `frame_done` pulses, `pcnt` clears, and the state returns to IDLE.
  - Weights arriving in RUN are dropped.
- `start` outside IDLE is ignored. A `start` on the same cycle that RUN→IDLE happens is also ignored.
- `valid_weight_out` is all-zero whenever no word is issued. At most one bit is ever set.
- Counter widths: `pcnt` is $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), `sel` is $clog2(NUM_PORTS), `wcnt` is COUNT_WIDTH. No wrap occurs within legal operation.
- **Reset at any time** (including mid-LOAD or mid-RUN):
  - state goes to IDLE;
  - all counters go to 0;
  - all outputs go to 0 on the next edge.
  - A partial weight load is discarded and must be restarted with `start`.

## Timing
- All outputs are registered. Weight path and pixel path latency is 1 cycle from input valid to output valid.
- `load_done` is asserted in the same cycle as the final `valid_weight_out` strobe.
- `frame_done` is asserted in the same cycle as the final `valid_out`.
- LOAD→RUN transition: a pixel presented in the cycle after the last weight is accepted. A pixel presented together with the last weight is dropped.
- Throughput is one weight or one pixel per cycle. Gaps in valid are allowed anywhere.
- There is no backpressure. Upstream must not exceed one word per cycle.

## Structure
- Shared package `layer3_pkg` holds:
  - the state encoding typedef (IDLE/LOAD/RUN);
  - NUM_PORTS = 19;
  - the per-port count constants, built from the layer-3 kernel sizes and channel depths, and the packed WEIGHT_COUNTS vector assembled from them.
- Port order is fixed:
  - ports 1–4 go to the conv block;
  - ports 5+3i, 6+3i, 7+3i go to weights 1/2/3 of identity block i (i = 0..4).
- One sub-module is natural: `layer3_port_counter`. It holds the `wcnt`/`sel` pair and the count-table lookup, and outputs `last_word`/`last_port`.
- The top-level FSM and pixel gating stay in this block.

## Test plan
- **Small load, one frame.** Config: WEIGHT_COUNTS all = 2, NUM_PORTS = 19, 8×8 image. Stimulus: `start`, 38 back-to-back weights of value 0..37. Expected: word n appears on bit n/2 one cycle later; `load_done` coincides with word 37; 64 pixels pass; `frame_done` comes with pixel 63; `busy` falls on the next cycle.
- **Gapped weights.** Stimulus: weights with 1-cycle gaps, mixed counts {1,3,2,…}. Expected: `valid_weight_out` is zero during gaps; boundaries are exact per count.
- **Dropped traffic.** Stimulus: pixels during IDLE/LOAD, weights during RUN. Expected: `valid_out` and `valid_weight_out` stay 0.
- **Ignored start.** Stimulus: `start` pulsed mid-LOAD and mid-RUN. Expected: `sel`/`pcnt` unaffected; exactly one `load_done` and one `frame_done`.
- **Reset mid-load.** Stimulus: assert `reset` after 10 of 38 words, then `start` with a full load. Expected: all outputs 0 the cycle after reset; word 0 of the new load goes to port 1.
- **Boundary pixel.** Stimulus: a pixel coincident with the last weight, then a pixel the next cycle. Expected: the first is dropped, the second passes, and `pcnt` counts from it.
